// File: rtl/lab5_pkg.sv
// Shared types and constants for the guess submitter and its slot register.
package lab5_pkg;

  localparam int         NUM_SLOTS = 4;
  localparam logic [3:0] WIN_COUNT = 4'd4;

  // Shape codes; 000 and 111 are not real shapes and are rejected on load.
  typedef enum logic [2:0] {
    SHAPE_NONE = 3'b000,
    SHAPE_1    = 3'b001,
    SHAPE_2    = 3'b010,
    SHAPE_3    = 3'b011,
    SHAPE_4    = 3'b100,
    SHAPE_5    = 3'b101,
    SHAPE_6    = 3'b110,
    SHAPE_BAD  = 3'b111
  } shape_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_GRADING,
    ST_WON,
    ST_LOST,
    ST_FAULT
  } sub_state_t;

  function automatic logic is_valid_shape(input shape_t s);
    return (s != SHAPE_NONE) && (s != SHAPE_BAD);
  endfunction

endpackage

// File: rtl/guess_register.sv
// Four-slot guess storage with a per-slot loaded mask and shape-code validation.
module guess_register
  import lab5_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic                   clear_all,
  input  logic                   clear_mask,
  input  logic [2:0]             shape,
  input  logic [1:0]             location,
  output logic [3*NUM_SLOTS-1:0] guess,
  output logic                   mask_full,
  output logic                   shape_error
);

  logic [NUM_SLOTS-1:0]   mask;
  logic [NUM_SLOTS-1:0]   mask_next;
  logic [NUM_SLOTS-1:0]   slot_bit;
  logic [3*NUM_SLOTS-1:0] guess_next;
  logic                   code_ok;
  logic                   write_ok;
  shape_t                 code;

  assign code     = shape_t'(shape);
  assign code_ok  = is_valid_shape(code);
  assign write_ok = load_en && code_ok;
  assign slot_bit = NUM_SLOTS'(1) << location;

  // Mask and guess as they will look after this cycle's load, so a same-cycle submit sees the new slot.
  always_comb begin
    mask_next  = mask;
    guess_next = guess;
    if (write_ok) begin
      mask_next = mask | slot_bit;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_bit[i]) guess_next[3*i +: 3] = shape;
      end
    end
  end

  assign mask_full = &mask_next;

  // Slot storage, mask bookkeeping and the one-cycle error pulse for rejected codes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask        <= '0;
      guess       <= '0;
      shape_error <= 1'b0;
    end else begin
      shape_error <= load_en && !code_ok;
      if (clear_all) begin
        mask  <= '0;
        guess <= '0;
      end else if (clear_mask) begin
        mask <= '0;
      end else begin
        mask  <= mask_next;
        guess <= guess_next;
      end
    end
  end

endmodule

// File: rtl/guess_submitter.sv
// Game-round controller: collects a four-slot guess, hands it to the grader,
// tracks rounds and results, and faults if the grader never answers.
module guess_submitter
  import lab5_pkg::*;
#(
  parameter int GRADE_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ongoingGame,
  input  logic [3:0]  numRounds,
  input  logic        loadGuessShape,
  input  logic [2:0]  guessShape,
  input  logic [1:0]  guessLocation,
  input  logic        submitGuess,
  input  logic        doneGrading,
  input  logic [3:0]  znarlyCount,
  input  logic [3:0]  zoodCount,
  output logic        gradeIt,
  output logic [11:0] guess,
  output logic [3:0]  roundNumber,
  output logic [3:0]  lastZnarly,
  output logic [3:0]  lastZood,
  output logic        gameWon,
  output logic        areRoundsLeft,
  output logic        gradeTimeout,
  output logic        shapeError
);

  localparam int TW = $clog2(GRADE_TIMEOUT + 1);

  sub_state_t     state;
  sub_state_t     state_next;
  logic [TW-1:0]  timer;
  logic [3:0]     rounds_limit;
  logic [3:0]     round_inc;
  logic           mask_full;
  logic           start;
  logic           grade_done;
  logic           load_en;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  assign round_inc  = sat_inc(roundNumber);
  assign start      = ongoingGame && (state == ST_IDLE);
  assign grade_done = ongoingGame && (state == ST_GRADING) && doneGrading;
  assign load_en    = ongoingGame && (state == ST_COLLECT) && loadGuessShape;

  guess_register u_guess_register (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .clear_all   (start),
    .clear_mask  (grade_done),
    .shape       (guessShape),
    .location    (guessLocation),
    .guess       (guess),
    .mask_full   (mask_full),
    .shape_error (shapeError)
  );

  // Next-state decode; dropping ongoingGame overrides everything, including a grade arriving that cycle.
  always_comb begin
    state_next = state;
    if (!ongoingGame) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_next = ST_COLLECT;
        ST_COLLECT: if (submitGuess && mask_full) state_next = ST_GRADING;
        ST_GRADING: begin
          if (doneGrading) begin
            if (znarlyCount == WIN_COUNT)       state_next = ST_WON;
            else if (round_inc >= rounds_limit) state_next = ST_LOST;
            else                                state_next = ST_COLLECT;
          end else if (timer == TW'(GRADE_TIMEOUT - 1)) begin
            state_next = ST_FAULT;
          end
        end
        default:    state_next = state;
      endcase
    end
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      gradeIt       <= 1'b0;
      gameWon       <= 1'b0;
      areRoundsLeft <= 1'b0;
      gradeTimeout  <= 1'b0;
      timer         <= '0;
    end else begin
      state         <= state_next;
      gradeIt       <= (state_next == ST_GRADING);
      gameWon       <= (state_next == ST_WON);
      areRoundsLeft <= (state_next == ST_COLLECT) || (state_next == ST_GRADING);
      gradeTimeout  <= (state_next == ST_FAULT);
      timer         <= ((state == ST_GRADING) && (state_next == ST_GRADING)) ? timer + TW'(1) : '0;
    end
  end

  // Round bookkeeping: cleared and limit latched on game start, updated when a grade lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      roundNumber  <= 4'd0;
      lastZnarly   <= 4'd0;
      lastZood     <= 4'd0;
      rounds_limit <= 4'd1;
    end else if (start) begin
      roundNumber  <= 4'd0;
      lastZnarly   <= 4'd0;
      lastZood     <= 4'd0;
      rounds_limit <= (numRounds == 4'd0) ? 4'd1 : numRounds;
    end else if (grade_done) begin
      roundNumber  <= round_inc;
      lastZnarly   <= znarlyCount;
      lastZood     <= zoodCount;
    end
  end

endmodule

// File: tb/tb_guess_submitter.sv
// Directed bench for guess_submitter: a vector table for one full game plus
// hand-written sequences for win, zero-round limit, timeout, abort and reset.
module tb_guess_submitter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ongoingGame = 1'b0;
  logic [3:0]  numRounds = 4'd2;
  logic        loadGuessShape = 1'b0;
  logic [2:0]  guessShape = 3'd0;
  logic [1:0]  guessLocation = 2'd0;
  logic        submitGuess = 1'b0;
  logic        doneGrading = 1'b0;
  logic [3:0]  znarlyCount = 4'd0;
  logic [3:0]  zoodCount = 4'd0;
  logic        gradeIt;
  logic [11:0] guess;
  logic [3:0]  roundNumber;
  logic [3:0]  lastZnarly;
  logic [3:0]  lastZood;
  logic        gameWon;
  logic        areRoundsLeft;
  logic        gradeTimeout;
  logic        shapeError;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  guess_submitter #(.GRADE_TIMEOUT(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .ongoingGame    (ongoingGame),
    .numRounds      (numRounds),
    .loadGuessShape (loadGuessShape),
    .guessShape     (guessShape),
    .guessLocation  (guessLocation),
    .submitGuess    (submitGuess),
    .doneGrading    (doneGrading),
    .znarlyCount    (znarlyCount),
    .zoodCount      (zoodCount),
    .gradeIt        (gradeIt),
    .guess          (guess),
    .roundNumber    (roundNumber),
    .lastZnarly     (lastZnarly),
    .lastZood       (lastZood),
    .gameWon        (gameWon),
    .areRoundsLeft  (areRoundsLeft),
    .gradeTimeout   (gradeTimeout),
    .shapeError     (shapeError)
  );

  typedef struct {
    logic        game;
    logic        load;
    logic [2:0]  shape;
    logic [1:0]  loc;
    logic        submit;
    logic        done;
    logic [3:0]  zn;
    logic [3:0]  zo;
    logic        x_grade;
    logic [11:0] x_guess;
    logic        x_err;
    logic        x_left;
    logic [3:0]  x_round;
    logic [3:0]  x_zn;
    logic [3:0]  x_zo;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic game, input logic load, input logic [2:0] shape, input logic [1:0] loc,
                     input logic submit, input logic done, input logic [3:0] zn, input logic [3:0] zo);
    ongoingGame    = game;
    loadGuessShape = load;
    guessShape     = shape;
    guessLocation  = loc;
    submitGuess    = submit;
    doneGrading    = done;
    znarlyCount    = zn;
    zoodCount      = zo;
    tick();
  endtask

  task automatic idle_cyc(input logic game);
    cyc(game, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  // Start a game from IDLE and fill all four slots with shape 001.
  task automatic start_and_fill();
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    for (int s = 0; s < 4; s++) cyc(1'b1, 1'b1, 3'b001, 2'(s), 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    //                game load shape  loc  sub done zn    zo    grade guess            err left round zn    zo
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000000000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000000000000, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000000000001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 3'b110, 2'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000000110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 3'b111, 2'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000100110001, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[9]  = '{1'b1, 1'b1, 3'b101, 2'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b101100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 12'b101100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[11] = '{1'b1, 1'b1, 3'b011, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 12'b101100110001, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 12'b101100110001, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 12'b101100110001, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[14] = '{1'b1, 1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b101100110010, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[15] = '{1'b1, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b101100010010, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 2'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b101010010010, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[17] = '{1'b1, 1'b1, 3'b011, 2'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 12'b011010010010, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2};
    vecs[18] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 12'b011010010010, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0};
    vecs[19] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 4'd4, 4'd3, 1'b0, 12'b011010010010, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0};
    vecs[20] = '{1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b011010010010, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0};
    vecs[21] = '{1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 12'b000000000000, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};

    // Reset state, checked while reset is held low.
    #2;
    chk("rst_gradeIt", 16'(gradeIt), 16'd0);
    chk("rst_guess", 16'(guess), 16'd0);
    chk("rst_round", 16'(roundNumber), 16'd0);
    chk("rst_zn", 16'(lastZnarly), 16'd0);
    chk("rst_zo", 16'(lastZood), 16'd0);
    chk("rst_flags", 16'({gameWon, areRoundsLeft, gradeTimeout, shapeError}), 16'd0);
    tick();
    tick();
    reset = 1'b1;

    // Main game from the vector table; numRounds=2 ends in LOST.
    numRounds = 4'd2;
    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].game, vecs[i].load, vecs[i].shape, vecs[i].loc, vecs[i].submit, vecs[i].done,
          vecs[i].zn, vecs[i].zo);
      chk($sformatf("v%0d_gradeIt", i), 16'(gradeIt), 16'(vecs[i].x_grade));
      chk($sformatf("v%0d_guess", i), 16'(guess), 16'(vecs[i].x_guess));
      chk($sformatf("v%0d_shapeError", i), 16'(shapeError), 16'(vecs[i].x_err));
      chk($sformatf("v%0d_roundsLeft", i), 16'(areRoundsLeft), 16'(vecs[i].x_left));
      chk($sformatf("v%0d_round", i), 16'(roundNumber), 16'(vecs[i].x_round));
      chk($sformatf("v%0d_lastZn", i), 16'(lastZnarly), 16'(vecs[i].x_zn));
      chk($sformatf("v%0d_lastZo", i), 16'(lastZood), 16'(vecs[i].x_zo));
      chk($sformatf("v%0d_gameWon", i), 16'(gameWon), 16'd0);
    end

    // Win on round 1; a 4-znarly grade wins even when it is also the last round.
    numRounds = 4'd1;
    start_and_fill();
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("win_gradeIt", 16'(gradeIt), 16'd1);
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 4'd0);
    chk("win_gameWon", 16'(gameWon), 16'd1);
    chk("win_round", 16'(roundNumber), 16'd1);
    chk("win_lastZn", 16'(lastZnarly), 16'd4);
    chk("win_gradeIt_low", 16'(gradeIt), 16'd0);
    chk("win_roundsLeft", 16'(areRoundsLeft), 16'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("win_hold", 16'(gameWon), 16'd1);
    chk("win_hold_gradeIt", 16'(gradeIt), 16'd0);
    idle_cyc(1'b0);
    chk("win_exit", 16'(gameWon), 16'd0);

    // numRounds=0 behaves as a single round: a non-winning grade loses.
    numRounds = 4'd0;
    start_and_fill();
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd3, 4'd1);
    chk("zero_rounds_left", 16'(areRoundsLeft), 16'd0);
    chk("zero_rounds_round", 16'(roundNumber), 16'd1);
    chk("zero_rounds_won", 16'(gameWon), 16'd0);
    chk("zero_rounds_zo", 16'(lastZood), 16'd1);

    // Grader never answers: gradeIt high for exactly 15 cycles, then FAULT.
    numRounds = 4'd5;
    start_and_fill();
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    begin
      int hi;
      hi = gradeIt ? 1 : 0;
      for (int i = 0; i < 40 && gradeIt; i++) begin
        idle_cyc(1'b1);
        if (gradeIt) hi++;
      end
      chk("timeout_len", 16'(hi), 16'd15);
    end
    chk("timeout_flag", 16'(gradeTimeout), 16'd1);
    chk("timeout_gradeIt", 16'(gradeIt), 16'd0);
    chk("timeout_roundsLeft", 16'(areRoundsLeft), 16'd0);
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 4'd0);
    chk("timeout_late_done", 16'({gradeTimeout, gameWon}), 16'b10);
    chk("timeout_late_round", 16'(roundNumber), 16'd0);
    idle_cyc(1'b0);
    chk("timeout_exit", 16'(gradeTimeout), 16'd0);

    // Abort by ongoingGame=0 while grading; a late doneGrading is ignored.
    start_and_fill();
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("abort_gradeIt_hi", 16'(gradeIt), 16'd1);
    cyc(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 4'd2);
    chk("abort_gradeIt", 16'(gradeIt), 16'd0);
    chk("abort_discard", 16'({gameWon, lastZnarly, roundNumber}), 16'd0);
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 4'd2);
    chk("abort_restart", 16'({areRoundsLeft, gradeIt, gameWon}), 16'b100);
    chk("abort_restart_round", 16'({roundNumber, lastZnarly, lastZood}), 16'd0);

    // Asynchronous reset while grading clears outputs without waiting for an edge.
    for (int s = 0; s < 4; s++) cyc(1'b1, 1'b1, 3'b110, 2'(s), 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("rst2_gradeIt_hi", 16'(gradeIt), 16'd1);
    chk("rst2_guess_hi", 16'(guess), 16'hDB6);
    #2;
    reset = 1'b0;
    #1;
    chk("rst2_gradeIt", 16'(gradeIt), 16'd0);
    chk("rst2_guess", 16'(guess), 16'd0);
    chk("rst2_roundsLeft", 16'(areRoundsLeft), 16'd0);
    doneGrading = 1'b1;
    znarlyCount = 4'd4;
    tick();
    reset = 1'b1;
    tick();
    chk("rst2_late_done", 16'({gameWon, gradeIt, areRoundsLeft}), 16'b001);
    chk("rst2_round", 16'({roundNumber, lastZnarly}), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_submitter.md
GUESS_SUBMITTER -- requirements
Module: guess_submitter

Interface
REQ-001 The block SHALL have parameter GRADE_TIMEOUT, default 15, the number of cycles to wait for doneGrading before faulting.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ongoingGame, input, 1 bit: game active; a low level aborts to IDLE.
REQ-005 The block SHALL have port numRounds, input, 4 bits: round limit, latched on game start.
REQ-006 The block SHALL have ports loadGuessShape (input, 1 bit, write strobe), guessShape (input, 3 bits, shape code) and guessLocation (input, 2 bits, slot index).
REQ-007 The block SHALL have port submitGuess, input, 1 bit: request grading of the current guess.
REQ-008 The block SHALL have ports doneGrading (input, 1 bit), znarlyCount (input, 4 bits) and zoodCount (input, 4 bits): grader handshake and results, valid when doneGrading=1.
REQ-009 The block SHALL have ports gradeIt (output, 1 bit, grading request) and guess (output, 12 bits, packed guess).
REQ-010 The block SHALL have ports roundNumber (output, 4 bits), lastZnarly (output, 4 bits) and lastZood (output, 4 bits).
REQ-011 The block SHALL have ports gameWon, areRoundsLeft, gradeTimeout and shapeError, each output, 1 bit.

Function
REQ-012 The FSM SHALL have states IDLE, COLLECT, GRADING, WON, LOST and FAULT.
REQ-013 IDLE SHALL go to COLLECT when ongoingGame=1, clearing the slot mask, guess, roundNumber and counts, and latching numRounds (0 is treated as 1).
REQ-014 Valid shape codes SHALL be 3'b001..3'b110; slot L SHALL occupy guess[3L+2:3L], so slot 3 is guess[11:9].
REQ-015 In COLLECT, loadGuessShape with a valid code SHALL write the slot and set its mask bit on the next edge.
REQ-016 In COLLECT, loadGuessShape with code 000 or 111 SHALL leave slot and mask unchanged and pulse shapeError high for one cycle.
REQ-017 In COLLECT, submitGuess SHALL be accepted only if the mask is 4'b1111 after any same-cycle load; otherwise it is ignored with no error.
REQ-018 On an accepted submit the FSM SHALL enter GRADING next cycle; the guess SHALL be frozen while in GRADING.
REQ-019 gradeIt SHALL be 1 exactly while in GRADING and held high until doneGrading=1 is sampled.
REQ-020 doneGrading SHALL be ignored outside GRADING.
REQ-021 When doneGrading=1 in GRADING, the block SHALL capture znarlyCount/zoodCount into lastZnarly/lastZood and increment roundNumber (saturating at 15).
REQ-022 On that same edge the next state SHALL be WON if znarlyCount=4, else LOST if the incremented roundNumber >= latched numRounds, else COLLECT with the mask cleared.
REQ-023 A cycle counter SHALL run in GRADING; if GRADE_TIMEOUT cycles pass without doneGrading, the FSM SHALL enter FAULT.
REQ-024 gameWon=1 SHALL hold only in WON, and gradeTimeout=1 only in FAULT.
REQ-025 areRoundsLeft SHALL be 1 in COLLECT and GRADING, and 0 otherwise.
REQ-026 WON, LOST and FAULT SHALL hold until ongoingGame=0.
REQ-027 ongoingGame=0 in any state SHALL return the FSM to IDLE on the next edge, dropping gradeIt and discarding any in-flight grade.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, with mask=0, guess=0, roundNumber=0, lastZnarly=0, lastZood=0, timeout counter=0, and all 1-bit outputs 0.
REQ-029 Reset deassertion SHALL NOT by itself start a game; ongoingGame must be sampled high.

Structure
REQ-030 Shared package lab5_pkg SHALL hold: the shape_t enum (3 bits), the submitter state enum, and constants NUM_SLOTS=4 and WIN_COUNT=4.
REQ-031 Slot storage, mask and shape validation SHALL live in sub-module guess_register; the FSM, timeout counter and round logic stay in guess_submitter.

Verification
REQ-032 Scenario: load slots 0..3 with 001,110,100,101, then submit -> guess=12'b101100110001, gradeIt=1 on the next cycle.
REQ-033 Scenario: submit with only 3 slots loaded -> gradeIt stays 0; load shape 111 -> shapeError pulses for 1 cycle and mask is unchanged.
REQ-034 Scenario: numRounds=2; grades (znarly 1, zood 2) then (znarly 2, zood 0) -> roundNumber=2, state LOST, areRoundsLeft=0, lastZnarly=2.
REQ-035 Scenario: doneGrading arrives with znarlyCount=4 on round 1 -> gameWon=1 and roundNumber=1; the state holds until ongoingGame=0, then returns to IDLE.
REQ-036 Scenario: submit and never assert doneGrading -> after 15 cycles in GRADING, gradeTimeout=1 and gradeIt=0.
REQ-037 Scenario: drop ongoingGame, or assert reset, while in GRADING -> IDLE, gradeIt=0 on the next edge (reset: immediately); a late doneGrading is ignored.
